// File: rtl/crc_tx_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crc_tx_sched_pkg
// Description : Shared state encoding and out_c bit positions for the
//               two-requester CRC frame transmit scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package crc_tx_sched_pkg;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_load    = 3'd1;
    localparam logic [2:0] c_st_payload = 3'd2;
    localparam logic [2:0] c_st_crc     = 3'd3;
    localparam logic [2:0] c_st_gap     = 3'd4;

    localparam int c_crc_stb    = 11;
    localparam int c_out_l      = 10;
    localparam int c_stb        = 9;
    localparam int c_out_p      = 8;

    localparam int c_crc_cycles = 4;

endpackage
`default_nettype wire

// File: rtl/crc_tx_sched_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter; on a tie the requester that was
//               not served last wins. Pointer updates when a grant is taken.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    // 1 = requester 1 was served last, so requester 0 wins the next tie
    logic r_last;

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_en && (|i_req)) begin
            r_last <= o_gnt[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/crc_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : crc_tx_sched
// Description : Arbitrates two frame requesters, streams the padded payload
//               from the granted source RAM, then a 4-cycle CRC window and
//               an interframe gap towards a downstream CRC generator.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_tx_sched
    import crc_tx_sched_pkg::*;
#(
    parameter int GAP    = 12,
    parameter int LW     = 11,
    parameter int MINLEN = 30
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [LW-1:0] len0,
    input  logic [LW-1:0] len1,
    output logic [1:0]    grant,
    output logic [LW-1:0] rd_addr,
    input  logic [7:0]    rd_data0,
    input  logic [7:0]    rd_data1,
    output logic [1:0]    done,
    output logic [11:0]   out_c
);

    // IDLE and LOAD each add a silent output cycle before the next frame,
    // so the GAP state itself is two cycles shorter than the visible gap.
    localparam int            c_gap_cyc  = (GAP > 2) ? (GAP - 2) : 1;
    localparam int            c_cw       = $clog2(c_gap_cyc + c_crc_cycles + 1);
    localparam logic [c_cw-1:0] c_gap_last = c_cw'(c_gap_cyc - 1);
    localparam logic [c_cw-1:0] c_crc_last = c_cw'(c_crc_cycles - 1);
    localparam logic [LW-1:0] c_minlen   = LW'(MINLEN);

    logic [2:0]      r_state, w_state_nxt;
    logic [1:0]      r_grant, w_grant_nxt;
    logic [LW-1:0]   r_addr,  w_addr_nxt;
    logic [c_cw-1:0] r_cnt,   w_cnt_nxt;
    logic [LW-1:0]   r_flen,  w_flen_nxt;
    logic [LW-1:0]   r_dlen,  w_dlen_nxt;
    logic            r_stb,   w_stb_nxt;
    logic            r_first, w_first_nxt;
    logic            r_lastb, w_lastb_nxt;
    logic            r_pass,  w_pass_nxt;
    logic            r_crc,   w_crc_nxt;
    logic [1:0]      r_done,  w_done_nxt;

    logic            w_arb_en;
    logic [1:0]      w_arb_gnt;
    logic [LW-1:0]   w_len_sel;
    logic [LW-1:0]   w_len_nz;
    logic [7:0]      w_data;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (req),
        .i_en  (w_arb_en),
        .o_gnt (w_arb_gnt)
    );

    always_comb begin
        w_len_sel = r_grant[1] ? len1 : len0;
        w_len_nz  = (w_len_sel == '0) ? LW'(1) : w_len_sel;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_flen_nxt  = r_flen;
        w_dlen_nxt  = r_dlen;
        w_arb_en    = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_arb_en = 1'b1;
                if (|req) begin
                    w_grant_nxt = w_arb_gnt;
                    w_state_nxt = c_st_load;
                end
            end
            c_st_load: begin
                w_dlen_nxt  = w_len_nz;
                w_flen_nxt  = (w_len_nz > c_minlen) ? w_len_nz : c_minlen;
                w_addr_nxt  = '0;
                w_state_nxt = c_st_payload;
            end
            c_st_payload: begin
                if (r_addr == r_flen - 1'b1) begin
                    w_addr_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_st_crc;
                end else begin
                    w_addr_nxt = r_addr + 1'b1;
                end
            end
            c_st_crc: begin
                if (r_cnt == c_crc_last) begin
                    w_cnt_nxt   = '0;
                    w_grant_nxt = 2'b00;
                    w_state_nxt = c_st_gap;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_st_gap: begin
                if (r_cnt == c_gap_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_st_idle;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_grant_nxt = 2'b00;
                w_addr_nxt  = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output flags are computed from the address issued this cycle and
    // registered, so they line up with the RAM data returned next cycle.
    always_comb begin
        w_stb_nxt   = (r_state == c_st_payload);
        w_first_nxt = w_stb_nxt && (r_addr == '0);
        w_lastb_nxt = w_stb_nxt && (r_addr == r_flen - 1'b1);
        w_pass_nxt  = w_stb_nxt && (r_addr < r_dlen);
        w_crc_nxt   = (r_state == c_st_crc);
        w_done_nxt  = (w_crc_nxt && (r_cnt == c_crc_last)) ? r_grant : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_grant <= 2'b00;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_flen  <= '0;
            r_dlen  <= '0;
            r_stb   <= 1'b0;
            r_first <= 1'b0;
            r_lastb <= 1'b0;
            r_pass  <= 1'b0;
            r_crc   <= 1'b0;
            r_done  <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_flen  <= w_flen_nxt;
            r_dlen  <= w_dlen_nxt;
            r_stb   <= w_stb_nxt;
            r_first <= w_first_nxt;
            r_lastb <= w_lastb_nxt;
            r_pass  <= w_pass_nxt;
            r_crc   <= w_crc_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_data = r_pass ? (r_grant[1] ? rd_data1 : rd_data0) : 8'h00;
        out_c             = 12'h000;
        out_c[c_crc_stb]  = r_crc;
        out_c[c_out_l]    = r_lastb;
        out_c[c_stb]      = r_stb;
        out_c[c_out_p]    = r_first;
        out_c[7:0]        = w_data;
    end

    assign grant   = r_grant;
    assign rd_addr = r_addr;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_crc_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_tx_sched
// Description : Self-checking bench for crc_tx_sched against a frame-level
//               reference model with randomized lengths and payload bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_tx_sched;

    localparam int GAP_C    = 12;
    localparam int MINLEN_C = 30;
    localparam int LW_C     = 11;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req;
    logic [LW_C-1:0] len0, len1;
    logic [1:0]      grant;
    logic [LW_C-1:0] rd_addr;
    logic [7:0]      rd_data0, rd_data1;
    logic [1:0]      done;
    logic [11:0]     out_c;

    crc_tx_sched #(.GAP(GAP_C), .LW(LW_C), .MINLEN(MINLEN_C)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .len0     (len0),
        .len1     (len1),
        .grant    (grant),
        .rd_addr  (rd_addr),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1),
        .done     (done),
        .out_c    (out_c)
    );

    always #5 clk = ~clk;

    logic [7:0] mem0 [0:2047];
    logic [7:0] mem1 [0:2047];

    always @(posedge clk) begin
        rd_data0 <= mem0[rd_addr];
        rd_data1 <= mem1[rd_addr];
    end

    int n_assert = 0;
    int n_fail   = 0;
    int last_served = 1;

    logic [7:0] obs_data[$];
    bit         obs_found;
    logic [1:0] obs_grant, obs_done_val;
    int obs_first_cnt, obs_first_idx, obs_last_cnt, obs_last_idx;
    int obs_crc, obs_crc_bad, obs_done_cnt, obs_done_at, obs_bad, obs_idle;

    function automatic int exp_len(input int len);
        int n;
        n = (len == 0) ? 1 : len;
        return (n > MINLEN_C) ? n : MINLEN_C;
    endfunction

    function automatic logic [7:0] exp_byte(input int src, input int idx, input int len);
        int n;
        n = (len == 0) ? 1 : len;
        if (idx >= n) return 8'h00;
        return (src == 1) ? mem1[idx] : mem0[idx];
    endfunction

    // Records one frame as seen on the outputs; starts and ends on a negedge.
    // drop_mode: 0 keep req, 1 clear served bit at done, 2 clear all at done.
    task automatic collect_frame(input int drop_mode, input int drop_byte);
        int t, i;
        obs_data.delete();
        obs_found = 1'b0; obs_grant = 2'b00; obs_done_val = 2'b00;
        obs_first_cnt = 0; obs_first_idx = -1; obs_last_cnt = 0; obs_last_idx = -1;
        obs_crc = 0; obs_crc_bad = 0; obs_done_cnt = 0; obs_done_at = -1;
        obs_bad = 0; obs_idle = 0;
        t = 0;
        while (out_c[8] !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        obs_found = (out_c[8] === 1'b1);
        if (!obs_found) return;
        obs_grant = grant;
        i = 0;
        while (out_c[9] === 1'b1 && i < 4096) begin
            obs_data.push_back(out_c[7:0]);
            if (out_c[8]) begin obs_first_cnt++; obs_first_idx = i; end
            if (out_c[10]) begin obs_last_cnt++; obs_last_idx = i; end
            if (out_c[11] || grant !== obs_grant) obs_bad++;
            if (done !== 2'b00) obs_done_cnt++;
            if (i == drop_byte) req = 2'b00;
            i++;
            @(negedge clk);
        end
        t = 0;
        while (out_c[11] === 1'b1 && t < 16) begin
            t++;
            obs_crc++;
            if (out_c[9] || out_c[10] || out_c[8] || out_c[7:0] !== 8'h00) obs_crc_bad++;
            if (!$onehot0(grant)) obs_bad++;
            if (done !== 2'b00) begin
                obs_done_cnt++; obs_done_at = t; obs_done_val = done;
                if (drop_mode == 1) req = req & ~done;
                else if (drop_mode == 2) req = 2'b00;
            end
            @(negedge clk);
        end
        t = 0;
        while (out_c === 12'h000 && t < 20) begin
            if (done !== 2'b00) obs_done_cnt++;
            if (!$onehot0(grant)) obs_bad++;
            t++;
            @(negedge clk);
        end
        obs_idle = t;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b00; len0 = '0; len1 = '0;
        repeat (2) @(negedge clk);
        n_assert++; if (out_c !== 12'h000) begin n_fail++; $display("FAIL reset_out_c got %h want 000", out_c); end
        n_assert++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got %b want 00", grant); end
        n_assert++; if (done !== 2'b00) begin n_fail++; $display("FAIL reset_done got %b want 00", done); end
        n_assert++; if (rd_addr !== '0) begin n_fail++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr); end
        rst = 1'b0;
        last_served = 1;
        @(negedge clk);
    endtask

    task automatic test_single_len40();
        int nbad;
        for (int i = 0; i < 2048; i++) mem0[i] = i[7:0];
        len0 = 11'd40; req = 2'b01;
        collect_frame(1, -1);
        n_assert++; if (!obs_found) begin n_fail++; $display("FAIL single_start got no out_p want out_p"); end
        n_assert++; if (obs_grant !== 2'b01) begin n_fail++; $display("FAIL single_grant got %b want 01", obs_grant); end
        n_assert++; if (obs_data.size() != 40) begin n_fail++; $display("FAIL single_strobes got %0d want 40", obs_data.size()); end
        nbad = 0;
        foreach (obs_data[i]) if (obs_data[i] !== 8'(i)) nbad++;
        n_assert++; if (nbad != 0) begin n_fail++; $display("FAIL single_data got %0d bad bytes want 0", nbad); end
        n_assert++; if (obs_first_cnt != 1 || obs_first_idx != 0) begin n_fail++; $display("FAIL single_out_p got %0d@%0d want 1@0", obs_first_cnt, obs_first_idx); end
        n_assert++; if (obs_last_cnt != 1 || obs_last_idx != 39) begin n_fail++; $display("FAIL single_out_l got %0d@%0d want 1@39", obs_last_cnt, obs_last_idx); end
        n_assert++; if (obs_crc != 4 || obs_crc_bad != 0) begin n_fail++; $display("FAIL single_crc got %0d cycles/%0d bad want 4/0", obs_crc, obs_crc_bad); end
        n_assert++; if (obs_done_cnt != 1 || obs_done_val !== 2'b01 || obs_done_at != 4) begin n_fail++; $display("FAIL single_done got %0d x %b @%0d want 1 x 01 @4", obs_done_cnt, obs_done_val, obs_done_at); end
        n_assert++; if (obs_idle < GAP_C || obs_bad != 0) begin n_fail++; $display("FAIL single_idle got idle %0d bad %0d want >=%0d/0", obs_idle, obs_bad, GAP_C); end
        last_served = 0;
    endtask

    task automatic test_short_pad();
        int nbad;
        for (int i = 0; i < 2048; i++) mem0[i] = 8'($urandom_range(1, 255));
        len0 = 11'd10; req = 2'b01;
        collect_frame(1, -1);
        n_assert++; if (obs_data.size() != 30) begin n_fail++; $display("FAIL pad_strobes got %0d want 30", obs_data.size()); end
        nbad = 0;
        foreach (obs_data[i]) if (obs_data[i] !== exp_byte(0, i, 10)) nbad++;
        n_assert++; if (nbad != 0) begin n_fail++; $display("FAIL pad_data got %0d bad bytes want 0", nbad); end
        n_assert++; if (obs_last_cnt != 1 || obs_last_idx != 29) begin n_fail++; $display("FAIL pad_out_l got %0d@%0d want 1@29", obs_last_cnt, obs_last_idx); end
        n_assert++; if (obs_done_val !== 2'b01 || obs_bad != 0) begin n_fail++; $display("FAIL pad_done got %b bad %0d want 01/0", obs_done_val, obs_bad); end
        last_served = 0;
    endtask

    task automatic test_random_frames();
        int lens[6] = '{0, 1, 29, 30, 31, 200};
        int src, len, nbad;
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < 2048; i++) begin
                mem0[i] = 8'($urandom);
                mem1[i] = 8'($urandom);
            end
            src = int'($urandom_range(0, 1));
            len = (f < 6) ? lens[f] : int'($urandom_range(0, 80));
            if (src == 1) len1 = 11'(len); else len0 = 11'(len);
            req = (src == 1) ? 2'b10 : 2'b01;
            collect_frame(1, -1);
            nbad = 0;
            foreach (obs_data[i]) if (obs_data[i] !== exp_byte(src, i, len)) nbad++;
            n_assert++; if (obs_grant !== req_bit(src)) begin n_fail++; $display("FAIL rand_grant f%0d got %b want %b", f, obs_grant, req_bit(src)); end
            n_assert++; if (obs_data.size() != exp_len(len)) begin n_fail++; $display("FAIL rand_strobes f%0d len %0d got %0d want %0d", f, len, obs_data.size(), exp_len(len)); end
            n_assert++; if (nbad != 0) begin n_fail++; $display("FAIL rand_data f%0d got %0d bad bytes want 0", f, nbad); end
            n_assert++; if (obs_first_idx != 0 || obs_last_idx != exp_len(len) - 1 || obs_first_cnt != 1 || obs_last_cnt != 1) begin n_fail++; $display("FAIL rand_flags f%0d got p%0d l%0d want p0 l%0d", f, obs_first_idx, obs_last_idx, exp_len(len) - 1); end
            n_assert++; if (obs_crc != 4 || obs_crc_bad != 0 || obs_done_at != 4 || obs_done_cnt != 1 || obs_done_val !== req_bit(src)) begin n_fail++; $display("FAIL rand_crc_done f%0d got crc %0d done %b@%0d want 4 %b@4", f, obs_crc, obs_done_val, obs_done_at, req_bit(src)); end
            n_assert++; if (obs_bad != 0) begin n_fail++; $display("FAIL rand_invariant f%0d got %0d violations want 0", f, obs_bad); end
            last_served = src;
        end
    endtask

    function automatic logic [1:0] req_bit(input int src);
        return (src == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic test_back_to_back();
        int src, len;
        for (int i = 0; i < 2048; i++) begin
            mem0[i] = 8'($urandom);
            mem1[i] = 8'($urandom);
        end
        len0 = 11'($urandom_range(0, 50));
        len1 = 11'($urandom_range(0, 50));
        req = 2'b11;
        for (int f = 0; f < 4; f++) begin
            src = (last_served == 1) ? 0 : 1;
            len = (src == 1) ? int'(len1) : int'(len0);
            collect_frame((f == 3) ? 2 : 0, -1);
            n_assert++; if (obs_grant !== req_bit(src)) begin n_fail++; $display("FAIL b2b_grant f%0d got %b want %b", f, obs_grant, req_bit(src)); end
            n_assert++; if (obs_data.size() != exp_len(len) || obs_done_val !== req_bit(src)) begin n_fail++; $display("FAIL b2b_frame f%0d got %0d/%b want %0d/%b", f, obs_data.size(), obs_done_val, exp_len(len), req_bit(src)); end
            if (f < 3) begin
                n_assert++; if (obs_idle != GAP_C) begin n_fail++; $display("FAIL b2b_gap f%0d got %0d idle want %0d", f, obs_idle, GAP_C); end
            end
            n_assert++; if (obs_bad != 0) begin n_fail++; $display("FAIL b2b_invariant f%0d got %0d violations want 0", f, obs_bad); end
            last_served = src;
        end
    endtask

    task automatic test_drop_mid();
        int nbad;
        for (int i = 0; i < 2048; i++) mem0[i] = 8'($urandom);
        len0 = 11'd33; req = 2'b01;
        collect_frame(0, 5);
        nbad = 0;
        foreach (obs_data[i]) if (obs_data[i] !== exp_byte(0, i, 33)) nbad++;
        n_assert++; if (obs_data.size() != 33 || nbad != 0) begin n_fail++; $display("FAIL drop_payload got %0d bytes %0d bad want 33/0", obs_data.size(), nbad); end
        n_assert++; if (obs_crc != 4 || obs_done_val !== 2'b01 || obs_done_cnt != 1) begin n_fail++; $display("FAIL drop_done got crc %0d done %b x%0d want 4 01 x1", obs_crc, obs_done_val, obs_done_cnt); end
        last_served = 0;
    endtask

    task automatic test_reset_mid();
        int t;
        len0 = 11'd40; len1 = 11'd40; req = 2'b01;
        t = 0;
        while (out_c[8] !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        n_assert++; if (out_c[8] !== 1'b1) begin n_fail++; $display("FAIL rstmid_start got no out_p want out_p"); end
        repeat (15) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_assert++; if (out_c !== 12'h000 || grant !== 2'b00 || done !== 2'b00) begin n_fail++; $display("FAIL rstmid_async got out_c %h grant %b done %b want 000 00 00", out_c, grant, done); end
        n_assert++; if (rd_addr !== '0) begin n_fail++; $display("FAIL rstmid_addr got %0d want 0", rd_addr); end
        req = 2'b11;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_served = 1;
        collect_frame(2, -1);
        n_assert++; if (obs_grant !== 2'b01) begin n_fail++; $display("FAIL rstmid_tie got %b want 01", obs_grant); end
        n_assert++; if (obs_data.size() != 40 || obs_done_cnt != 1 || obs_done_val !== 2'b01) begin n_fail++; $display("FAIL rstmid_frame got %0d/%0d/%b want 40/1/01", obs_data.size(), obs_done_cnt, obs_done_val); end
        last_served = 0;
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; len0 = '0; len1 = '0;
        for (int i = 0; i < 2048; i++) begin mem0[i] = 8'h00; mem1[i] = 8'h00; end
        test_reset();
        test_single_len40();
        test_short_pad();
        test_random_frames();
        test_back_to_back();
        test_drop_mid();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crc_tx_sched.md
CRC_TX_SCHED -- requirements
Module: crc_tx_sched

Interface
REQ-001 Parameter GAP, default 12, interframe idle cycles after each CRC window.
REQ-002 Parameter LW, default 11, width of length and address fields.
REQ-003 Parameter MINLEN, default 30, minimum payload bytes; shorter requests are padded with 8'h00.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  2  per-requester frame request, level, held until done.
REQ-007 len0, len1  input  LW each  payload byte count of requester 0/1, stable while req is high; 0 is treated as 1.
REQ-008 grant  output  2  one-hot owner of the bus; 2'b00 when idle.
REQ-009 rd_addr  output  LW  byte index requested from the granted source.
REQ-010 rd_data0, rd_data1  input  8 each  source byte for rd_addr, valid exactly one cycle after rd_addr (synchronous RAM read).
REQ-011 done  output  2  one-cycle pulse to the served requester on the last CRC cycle.
REQ-012 out_c  output  12  {crc_strobe, out_l, strobe, out_p, data[7:0]} to the downstream CRC generator.

Function
REQ-013 States: IDLE, LOAD, PAYLOAD, CRC, GAP; reset state IDLE.
REQ-014 IDLE: if any req, go to LOAD with a grant chosen round-robin (the requester not served last wins a tie); after reset requester 0 wins a tie.
REQ-015 LOAD (1 cycle): latch effective length L = max(len, MINLEN), set rd_addr=0, go to PAYLOAD.
REQ-016 PAYLOAD: rd_addr increments by 1 each cycle until L-1, then go to CRC.
REQ-017 out_c is registered: it is driven from state/address one cycle after rd_addr is issued, so strobe aligns with the RAM output.
REQ-018 strobe=1 for exactly L consecutive cycles per frame; data = granted rd_data when index < len, else 8'h00.
REQ-019 out_p=1 only on the first strobe cycle; out_l=1 only on the last strobe cycle.
REQ-020 CRC: crc_strobe=1, strobe=0, data=8'h00 for exactly 4 cycles, immediately following the last strobe cycle.
REQ-021 done pulses for the granted requester concurrently with the 4th crc_strobe cycle.
REQ-022 GAP: out_c=0 for GAP cycles after CRC; grant drops to 0 on entering GAP; then IDLE.
REQ-023 A req deassertion mid-frame is ignored; the frame completes with the latched L.
REQ-024 A new request arriving in any non-IDLE state waits; no preemption.
REQ-025 Counter arithmetic is LW bits; L up to 2^LW-1 without wrap.
REQ-026 All outputs not otherwise specified are 0 in IDLE and GAP.

Reset
REQ-027 rst asserted at any time forces IDLE, grant=0, done=0, out_c=0, rd_addr=0, round-robin pointer to "requester 1 last served", asynchronously.
REQ-028 A frame interrupted by rst is abandoned; no done pulse is issued for it.

Structure
REQ-029 A shared package holds the state encoding and the out_c bit positions (CRC_STB=11, OUT_L=10, STB=9, OUT_P=8).
REQ-030 One sub-module, rr_arb2 (two-way round-robin arbiter with last-served pointer), is used; everything else is in crc_tx_sched.

Verification
REQ-031 req=01, len0=40, source byte=index: 40 strobe cycles, data 0..39, out_p on first, out_l on 40th, 4 crc_strobe cycles, done=01, then 12 idle cycles.
REQ-032 len0=10: 30 strobe cycles, bytes 10..29 equal 8'h00, out_l on 30th.
REQ-033 req=11 held continuously: grants alternate 01,10,01,... with exactly 12 idle cycles between CRC end and next out_p.
REQ-034 rst pulsed during PAYLOAD byte 15: out_c, grant, done go 0 immediately; after release, tie goes to requester 0.
REQ-035 req0 dropped at byte 5 of a 33-byte frame: all 33 bytes plus CRC still emitted, done=01 pulses.
REQ-036 Scoreboard on all runs: strobe count per frame = max(len,30), out_c never has strobe and crc_strobe together, grant always one-hot or zero.
